// File: rtl/idex_hazard_ctrl.sv
// Interlock and forwarding controller for the ID/EX pipeline register.
// Drives IF/ID hold and flush, the ID/EX bubble, the mul/div start pulse and the EX operand selects.
module idex_hazard_ctrl #(
    parameter int WordSize    = 32,
    parameter int FlushCycles = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                id_valid,
    input  logic [4:0]          id_rs1n,
    input  logic [4:0]          id_rs2n,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_is_mdu,
    input  logic [4:0]          ex_rdn,
    input  logic                ex_is_load,
    input  logic [4:0]          mem_rdn,
    input  logic [4:0]          wb_rdn,
    input  logic                branch_taken,
    input  logic                mdu_done,
    output logic                stall_if,
    output logic                idex_bubble,
    output logic                flush_ifid,
    output logic                mdu_start,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [1:0]          ctrl_state,
    output logic [WordSize-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MDU_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [2:0]          FlushReload = 3'(FlushCycles - 1);
    localparam logic [WordSize-1:0] CountMax    = '1;
    // A single-cycle flush needs no FLUSH state: the branch cycle itself is the only flush cycle.
    localparam state_t              BranchNext  = (FlushCycles == 1) ? RUN : FLUSH;

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic [4:0] ex_rs1n, ex_rs2n;
    logic       load_use;
    logic       ctl_stall, ctl_bubble, ctl_flush, ctl_start;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_dst,
                                           input logic [4:0] wb_dst);
        if (mem_dst != 5'd0 && mem_dst == src)
            return 2'd1;
        else if (wb_dst != 5'd0 && wb_dst == src)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        load_use = id_valid && ex_is_load && (ex_rdn != 5'd0) &&
                   ((id_uses_rs1 && id_rs1n == ex_rdn) || (id_uses_rs2 && id_rs2n == ex_rdn));
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_next     = state;
        flush_cnt_next = flush_cnt;
        ctl_stall      = 1'b0;
        ctl_bubble     = 1'b0;
        ctl_flush      = 1'b0;
        ctl_start      = 1'b0;
        unique case (state)
            RUN, LOAD_STALL: begin
                if (branch_taken) begin
                    ctl_flush      = 1'b1;
                    ctl_bubble     = 1'b1;
                    flush_cnt_next = FlushReload;
                    state_next     = BranchNext;
                end else if (state == LOAD_STALL) begin
                    state_next = RUN;
                end else if (id_valid && id_is_mdu) begin
                    ctl_start  = 1'b1;
                    ctl_stall  = 1'b1;
                    ctl_bubble = 1'b1;
                    state_next = MDU_WAIT;
                end else if (load_use) begin
                    ctl_stall  = 1'b1;
                    ctl_bubble = 1'b1;
                    state_next = LOAD_STALL;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_next = RUN;
                end else begin
                    ctl_stall  = 1'b1;
                    ctl_bubble = 1'b1;
                end
            end
            FLUSH: begin
                ctl_flush  = 1'b1;
                ctl_bubble = 1'b1;
                if (branch_taken) begin
                    flush_cnt_next = FlushReload;
                    state_next     = BranchNext;
                end else if (flush_cnt <= 3'd1) begin
                    // The count holds the FLUSH cycles still owed, this one included.
                    flush_cnt_next = 3'd0;
                    state_next     = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
        endcase
    end

    // Controls are forced low while reset is held so no pulse escapes mid-reset.
    assign stall_if    = rstn & ctl_stall;
    assign idex_bubble = rstn & ctl_bubble;
    assign flush_ifid  = rstn & ctl_flush;
    assign mdu_start   = rstn & ctl_start;
    assign ctrl_state  = state;
    assign fwd_a       = fwd_sel(ex_rs1n, mem_rdn, wb_rdn);
    assign fwd_b       = fwd_sel(ex_rs2n, mem_rdn, wb_rdn);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_rs1n <= 5'd0;
            ex_rs2n <= 5'd0;
        end else if (!ctl_stall && !ctl_bubble) begin
            ex_rs1n <= id_rs1n;
            ex_rs2n <= id_rs2n;
        end else if (ctl_bubble) begin
            ex_rs1n <= 5'd0;
            ex_rs2n <= 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_count <= '0;
        else if (stall_if && stall_count != CountMax)
            stall_count <= stall_count + WordSize'(1);
    end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Bench for idex_hazard_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a flag-based behavioural model of the interlock rules.
module tb_idex_hazard_ctrl;

    localparam int W      = 6;
    localparam int FC     = 2;
    localparam int CNTMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         id_valid, id_uses_rs1, id_uses_rs2, id_is_mdu;
    logic [4:0]   id_rs1n, id_rs2n, ex_rdn, mem_rdn, wb_rdn;
    logic         ex_is_load, branch_taken, mdu_done;
    logic         stall_if, idex_bubble, flush_ifid, mdu_start;
    logic [1:0]   fwd_a, fwd_b, ctrl_state;
    logic [W-1:0] stall_count;

    int n_checks = 0;
    int n_err    = 0;

    idex_hazard_ctrl #(.WordSize(W), .FlushCycles(FC)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_rs1n(id_rs1n), .id_rs2n(id_rs2n),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_mdu(id_is_mdu),
        .ex_rdn(ex_rdn), .ex_is_load(ex_is_load), .mem_rdn(mem_rdn), .wb_rdn(wb_rdn),
        .branch_taken(branch_taken), .mdu_done(mdu_done),
        .stall_if(stall_if), .idex_bubble(idex_bubble), .flush_ifid(flush_ifid),
        .mdu_start(mdu_start), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ctrl_state(ctrl_state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending obligations are tracked as plain flags and a remaining-cycle count.
    bit  m_mdu_busy, m_load_pending;
    int  m_flush_left, m_stalls, m_ex_rs1, m_ex_rs2;
    bit  lu;
    logic e_stall, e_bubble, e_flush, e_start;
    logic [1:0] e_state, e_fa, e_fb;

    function automatic logic [1:0] src_of(input int name);
        if (mem_rdn != 0 && int'(mem_rdn) == name) return 2'd1;
        if (wb_rdn != 0 && int'(wb_rdn) == name) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        lu = id_valid && ex_is_load && ex_rdn != 0 &&
             ((id_uses_rs1 && id_rs1n == ex_rdn) || (id_uses_rs2 && id_rs2n == ex_rdn));
        e_stall = 1'b0; e_bubble = 1'b0; e_flush = 1'b0; e_start = 1'b0;
        e_state = m_mdu_busy ? 2'd2 : (m_flush_left > 0) ? 2'd3 : m_load_pending ? 2'd1 : 2'd0;
        if (!rstn) begin
            e_state = 2'd0;
        end else if (m_mdu_busy) begin
            if (!mdu_done) begin e_stall = 1'b1; e_bubble = 1'b1; end
        end else if (branch_taken || m_flush_left > 0) begin
            e_flush = 1'b1; e_bubble = 1'b1;
        end else if (m_load_pending) begin
            e_stall = 1'b0;
        end else if (id_valid && id_is_mdu) begin
            e_start = 1'b1; e_stall = 1'b1; e_bubble = 1'b1;
        end else if (lu) begin
            e_stall = 1'b1; e_bubble = 1'b1;
        end
        e_fa = src_of(m_ex_rs1);
        e_fb = src_of(m_ex_rs2);
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mdu_busy <= 0; m_load_pending <= 0; m_flush_left <= 0;
            m_stalls <= 0; m_ex_rs1 <= 0; m_ex_rs2 <= 0;
        end else begin
            if (e_stall) m_stalls <= m_stalls + 1;
            if (m_mdu_busy) begin
                if (mdu_done) m_mdu_busy <= 0;
            end else if (branch_taken) begin
                m_flush_left <= FC - 1; m_load_pending <= 0;
            end else if (m_flush_left > 0) begin
                m_flush_left <= m_flush_left - 1;
            end else if (m_load_pending) begin
                m_load_pending <= 0;
            end else if (id_valid && id_is_mdu) begin
                m_mdu_busy <= 1;
            end else if (lu) begin
                m_load_pending <= 1;
            end
            if (!e_stall && !e_bubble) begin
                m_ex_rs1 <= int'(id_rs1n); m_ex_rs2 <= int'(id_rs2n);
            end else if (e_bubble) begin
                m_ex_rs1 <= 0; m_ex_rs2 <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("stall_if", 32'(stall_if), 32'(e_stall));
        check("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
        check("flush_ifid", 32'(flush_ifid), 32'(e_flush));
        check("mdu_start", 32'(mdu_start), 32'(e_start));
        check("ctrl_state", 32'(ctrl_state), 32'(e_state));
        check("fwd_a", 32'(fwd_a), 32'(e_fa));
        check("fwd_b", 32'(fwd_b), 32'(e_fb));
        check("stall_count", 32'(stall_count), 32'((m_stalls > CNTMAX) ? CNTMAX : m_stalls));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_valid = 0; id_rs1n = 0; id_rs2n = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_is_mdu = 0; ex_rdn = 0; ex_is_load = 0; mem_rdn = 0; wb_rdn = 0;
        branch_taken = 0; mdu_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rstn = 0;
        next_cycle(); next_cycle();
        rstn = 1;
    endtask

    initial begin
        idle(); rstn = 0;
        next_cycle(); next_cycle();
        mid();
        check("reset_state", 32'(ctrl_state), 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        next_cycle(); rstn = 1;

        // Load-use: one bubble, then forwarding from EX/MEM.
        ex_is_load = 1; ex_rdn = 5; id_valid = 1; id_rs1n = 5; id_uses_rs1 = 1;
        mid();
        check("lu_stall", 32'(stall_if), 32'd1);
        check("lu_bubble", 32'(idex_bubble), 32'd1);
        next_cycle(); ex_is_load = 0; ex_rdn = 0;
        mid();
        check("lu_release", 32'(stall_if), 32'd0);
        check("lu_state", 32'(ctrl_state), 32'd1);
        next_cycle(); idle(); mem_rdn = 5;
        mid();
        check("lu_fwd_a", 32'(fwd_a), 32'd1);
        check("lu_count", 32'(stall_count), 32'd1);
        next_cycle(); idle();

        // x0 never hazards or forwards.
        ex_is_load = 1; id_valid = 1; id_uses_rs1 = 1;
        mid();
        check("x0_nostall", 32'(stall_if), 32'd0);
        next_cycle(); idle();
        mid();
        check("x0_fwd_a", 32'(fwd_a), 32'd0);
        check("x0_fwd_b", 32'(fwd_b), 32'd0);

        // Branch flush: branch cycle plus one FLUSH cycle, then a re-armed flush.
        next_cycle(); branch_taken = 1;
        mid(); check("br_flush0", 32'(flush_ifid), 32'd1);
        next_cycle(); branch_taken = 0;
        mid(); check("br_flush1", 32'(flush_ifid), 32'd1);
        check("br_state1", 32'(ctrl_state), 32'd3);
        next_cycle();
        mid(); check("br_done", 32'(flush_ifid), 32'd0);
        check("br_run", 32'(ctrl_state), 32'd0);
        next_cycle(); branch_taken = 1;
        next_cycle();
        mid(); check("br2_flush1", 32'(flush_ifid), 32'd1);
        next_cycle(); branch_taken = 0;
        mid(); check("br2_flush2", 32'(flush_ifid), 32'd1);
        check("br2_state", 32'(ctrl_state), 32'd3);
        next_cycle();
        mid(); check("br2_done", 32'(flush_ifid), 32'd0);

        // MDU beats a simultaneous load-use; four stall cycles.
        next_cycle(); do_reset();
        id_valid = 1; id_is_mdu = 1; id_rs1n = 5; id_uses_rs1 = 1; ex_is_load = 1; ex_rdn = 5;
        mid(); check("mdu_start0", 32'(mdu_start), 32'd1);
        check("mdu_stall0", 32'(stall_if), 32'd1);
        next_cycle(); ex_is_load = 0; ex_rdn = 0;
        mid(); check("mdu_start1", 32'(mdu_start), 32'd0);
        check("mdu_state1", 32'(ctrl_state), 32'd2);
        next_cycle(); next_cycle();
        mid(); check("mdu_stall3", 32'(stall_if), 32'd1);
        next_cycle(); mdu_done = 1;
        mid(); check("mdu_release", 32'(stall_if), 32'd0);
        next_cycle(); idle();
        mid(); check("mdu_count", 32'(stall_count), 32'd4);
        check("mdu_run", 32'(ctrl_state), 32'd0);

        // Forward priority: EX/MEM over MEM/WB.
        next_cycle(); id_valid = 1; id_rs2n = 7; id_uses_rs2 = 1;
        next_cycle(); mem_rdn = 7; wb_rdn = 7;
        mid(); check("fwd_b_mem", 32'(fwd_b), 32'd1);
        next_cycle(); mem_rdn = 3;
        mid(); check("fwd_b_wb", 32'(fwd_b), 32'd2);

        // Asynchronous reset in the middle of an MDU wait.
        next_cycle(); idle(); id_valid = 1; id_is_mdu = 1;
        next_cycle(); id_is_mdu = 0;
        next_cycle(); #2;
        idle(); rstn = 0; #1;
        check("arst_stall", 32'(stall_if), 32'd0);
        check("arst_bubble", 32'(idex_bubble), 32'd0);
        check("arst_state", 32'(ctrl_state), 32'd0);
        check("arst_count", 32'(stall_count), 32'd0);
        next_cycle(); rstn = 1;
        mid(); check("arst_nostart", 32'(mdu_start), 32'd0);
        check("arst_run", 32'(ctrl_state), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            if ($urandom_range(0, 399) == 0) begin
                idle(); rstn = 0;
                continue;
            end
            rstn         = 1;
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1n      = 5'($urandom_range(0, 7));
            id_rs2n      = 5'($urandom_range(0, 7));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            id_is_mdu    = ($urandom_range(0, 9) == 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_rdn       = 5'($urandom_range(0, 7));
            mem_rdn      = 5'($urandom_range(0, 7));
            wb_rdn       = 5'($urandom_range(0, 7));
            branch_taken = ($urandom_range(0, 7) == 0);
            mdu_done     = ($urandom_range(0, 5) == 0);
        end
        next_cycle(); rstn = 1; idle();
        next_cycle();
        mid();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
